// File: rtl/conv3x3_edge_engine.sv
// 3x3 window engine: two line buffers, Sobel Gx/Gy, magnitude scale,
// saturation and threshold, with bypass of the centre pixel.
module conv3x3_edge_engine #(
    parameter int DW        = 12,
    parameter int ROW_WIDTH = 640,
    parameter int SHIFT     = 3,
    parameter int CW        = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic          iFSTART,
    input  logic [1:0]    iMode,
    input  logic [DW-1:0] iThresh,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic          oFSTART
);

    localparam int AW = $clog2(ROW_WIDTH);
    localparam int SW = DW + 3;

    logic [DW-1:0] r_buf_a [ROW_WIDTH];
    logic [DW-1:0] r_buf_b [ROW_WIDTH];

    logic [CW-1:0] r_col;
    logic [1:0]    r_row;
    logic [1:0]    r_mode;
    logic [DW-1:0] r_thresh;

    logic [DW-1:0] r_win [3][3];
    logic          r_v1, r_fs1, r_bord1;

    logic signed [SW-1:0] r_gx, r_gy;
    logic [DW-1:0]        r_c2;
    logic                 r_v2, r_fs2, r_bord2;

    logic [DW-1:0] r_odata;
    logic          r_odval, r_ofs;

    logic [CW-1:0]        w_col;
    logic [1:0]           w_row;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_tap1, w_tap2;
    logic [DW+1:0]        w_sl, w_sr, w_st, w_sb;
    logic signed [SW-1:0] w_gx, w_gy;
    logic [SW-1:0]        w_ax, w_ay;
    logic [DW+3:0]        w_mag, w_scl;
    logic [DW-1:0]        w_sat, w_out;

    // A frame-start pixel is always position (0,0)
    assign w_col  = iFSTART ? '0 : r_col;
    assign w_row  = iFSTART ? 2'd0 : r_row;
    assign w_addr = w_col[AW-1:0];
    assign w_tap1 = r_buf_a[w_addr];
    assign w_tap2 = r_buf_b[w_addr];

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            r_buf_a[w_addr] <= iDATA;
            r_buf_b[w_addr] <= w_tap1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_col    <= '0;
            r_row    <= 2'd0;
            r_mode   <= 2'b00;
            r_thresh <= '0;
        end else begin
            if (iFSTART) begin
                r_mode   <= iMode;
                r_thresh <= iThresh;
            end
            if (iDVAL) begin
                if (w_col == CW'(ROW_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == 2'd2) ? w_row : w_row + 2'd1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end else if (iFSTART) begin
                r_col <= '0;
                r_row <= 2'd0;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= '0;
            r_v1    <= 1'b0;
            r_fs1   <= 1'b0;
            r_bord1 <= 1'b0;
        end else begin
            r_v1  <= iDVAL;
            r_fs1 <= iFSTART;
            if (iDVAL) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_tap2;
                r_win[1][2] <= w_tap1;
                r_win[2][2] <= iDATA;
                r_bord1     <= (w_row < 2'd2) || (w_col < CW'(2));
            end
        end
    end

    assign w_sl = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    assign w_sr = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    assign w_st = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};
    assign w_sb = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    assign w_gx = $signed({1'b0, w_sr}) - $signed({1'b0, w_sl});
    assign w_gy = $signed({1'b0, w_sb}) - $signed({1'b0, w_st});

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_gx    <= '0;
            r_gy    <= '0;
            r_c2    <= '0;
            r_bord2 <= 1'b0;
            r_v2    <= 1'b0;
            r_fs2   <= 1'b0;
        end else begin
            r_v2  <= r_v1;
            r_fs2 <= r_fs1;
            if (r_v1) begin
                r_gx    <= w_gx;
                r_gy    <= w_gy;
                r_c2    <= r_win[1][1];
                r_bord2 <= r_bord1;
            end
        end
    end

    assign w_ax = r_gx[SW-1] ? SW'(-r_gx) : SW'(r_gx);
    assign w_ay = r_gy[SW-1] ? SW'(-r_gy) : SW'(r_gy);

    always_comb begin
        w_mag = '0;
        case (r_mode)
            2'b00:   w_mag = {1'b0, w_ax} + {1'b0, w_ay};
            2'b01:   w_mag = {1'b0, w_ax};
            2'b10:   w_mag = {1'b0, w_ay};
            default: w_mag = '0;
        endcase
    end

    assign w_scl = w_mag >> SHIFT;
    assign w_sat = (|w_scl[DW+3:DW]) ? {DW{1'b1}} : w_scl[DW-1:0];

    always_comb begin
        w_out = '0;
        if (r_bord2)
            w_out = '0;
        else if (r_mode == 2'b11)
            w_out = r_c2;
        else if (w_sat < r_thresh)
            w_out = '0;
        else
            w_out = w_sat;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_odata <= '0;
            r_odval <= 1'b0;
            r_ofs   <= 1'b0;
        end else begin
            r_odval <= r_v2;
            r_ofs   <= r_fs2;
            if (r_v2)
                r_odata <= w_out;
        end
    end

    assign oDATA   = r_odata;
    assign oDVAL   = r_odval;
    assign oFSTART = r_ofs;

endmodule

// File: tb/tb_conv3x3_edge_engine.sv
// Scoreboard bench: two engines (SHIFT=3 and SHIFT=0) share one stimulus
// stream; an image-level Sobel model predicts each output pixel.
module tb_conv3x3_edge_engine;

    typedef struct {
        int val;
        bit fs;
        int cyc;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [11:0] iDATA = '0;
    logic        iDVAL = 1'b0;
    logic        iFSTART = 1'b0;
    logic [1:0]  iMode = 2'b00;
    logic [11:0] iThresh = '0;
    logic [11:0] oDATA_m, oDATA_s;
    logic        oDVAL_m, oDVAL_s;
    logic        oFSTART_m, oFSTART_s;

    exp_t q_m[$];
    exp_t q_s[$];
    int   fimg [8][8];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [1:0] mode_m = 2'b00;
    int   thr_m = 0;

    conv3x3_edge_engine #(.DW(12), .ROW_WIDTH(8), .SHIFT(3), .CW(4)) u_main (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
        .iFSTART(iFSTART), .iMode(iMode), .iThresh(iThresh),
        .oDATA(oDATA_m), .oDVAL(oDVAL_m), .oFSTART(oFSTART_m)
    );

    conv3x3_edge_engine #(.DW(12), .ROW_WIDTH(8), .SHIFT(0), .CW(4)) u_sat (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
        .iFSTART(iFSTART), .iMode(iMode), .iThresh(iThresh),
        .oDATA(oDATA_s), .oDVAL(oDVAL_s), .oFSTART(oFSTART_s)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int model(int r, int c, int sh);
        int gx, gy, mag, s;
        if (r < 2 || c < 2) return 0;
        if (mode_m == 2'b11) return fimg[r-1][c-1];
        gx = (fimg[r-2][c] + 2*fimg[r-1][c] + fimg[r][c])
           - (fimg[r-2][c-2] + 2*fimg[r-1][c-2] + fimg[r][c-2]);
        gy = (fimg[r][c-2] + 2*fimg[r][c-1] + fimg[r][c])
           - (fimg[r-2][c-2] + 2*fimg[r-2][c-1] + fimg[r-2][c]);
        case (mode_m)
            2'b00:   mag = iabs(gx) + iabs(gy);
            2'b01:   mag = iabs(gx);
            default: mag = iabs(gy);
        endcase
        s = mag >> sh;
        if (s > 4095) s = 4095;
        if (s < thr_m) s = 0;
        return s;
    endfunction

    function automatic int pix(int kind, int r, int c);
        case (kind)
            0:       return (c >= 4) ? 100 : 0;
            1:       return (r >= 4) ? 100 : 0;
            2:       return (c >= 4) ? 4095 : 0;
            default: return (r*131 + c*71 + r*c*29 + 17) % 4096;
        endcase
    endfunction

    task automatic idle();
        @(posedge iCLK); #1;
        iDVAL   = 1'b0;
        iFSTART = 1'b0;
        iDATA   = 12'($urandom);
    endtask

    task automatic issue(bit fs, logic [1:0] md, int thr, int v, int r, int c);
        exp_t e;
        @(posedge iCLK); #1;
        iDATA   = 12'(v);
        iDVAL   = 1'b1;
        iFSTART = fs;
        iMode   = md;
        iThresh = 12'(thr);
        if (fs) begin
            mode_m = md;
            thr_m  = thr;
        end
        fimg[r][c] = v;
        e.fs  = fs;
        e.cyc = cyc + 3;
        e.val = model(r, c, 3);
        q_m.push_back(e);
        e.val = model(r, c, 0);
        q_s.push_back(e);
    endtask

    task automatic send_frame(int kind, logic [1:0] m0, logic [1:0] m1,
                              int t0, int t1, int gap);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int k;
                k = r*8 + c;
                if (gap > 0)
                    while ($urandom_range(0, 99) < gap) idle();
                issue(k == 0, (k < 32) ? m0 : m1, (k < 32) ? t0 : t1,
                      pix(kind, r, c), r, c);
            end
        end
        repeat (4) idle();
    endtask

    task automatic chk(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_zero_out(string tag);
        chk({tag, "_odata_m"}, int'(oDATA_m), 0);
        chk({tag, "_odval_m"}, int'(oDVAL_m), 0);
        chk({tag, "_ofs_m"},   int'(oFSTART_m), 0);
        chk({tag, "_odata_s"}, int'(oDATA_s), 0);
        chk({tag, "_odval_s"}, int'(oDVAL_s), 0);
        chk({tag, "_ofs_s"},   int'(oFSTART_s), 0);
    endtask

    always @(negedge iCLK) begin
        exp_t e;
        if (oFSTART_m && !oDVAL_m) begin
            n_err++;
            $display("FAIL main_fs_without_valid cyc=%0d", cyc);
        end
        if (oDVAL_m) begin
            n_vec++;
            if (q_m.size() == 0) begin
                n_err++;
                $display("FAIL main_unexpected data=%0d cyc=%0d", oDATA_m, cyc);
            end else begin
                e = q_m.pop_front();
                if (oDATA_m !== 12'(e.val) || oFSTART_m !== e.fs || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL main_px got data=%0d fs=%0b cyc=%0d want data=%0d fs=%0b cyc=%0d",
                             oDATA_m, oFSTART_m, cyc, e.val, e.fs, e.cyc);
                end
            end
        end
    end

    always @(negedge iCLK) begin
        exp_t e;
        if (oFSTART_s && !oDVAL_s) begin
            n_err++;
            $display("FAIL sat_fs_without_valid cyc=%0d", cyc);
        end
        if (oDVAL_s) begin
            n_vec++;
            if (q_s.size() == 0) begin
                n_err++;
                $display("FAIL sat_unexpected data=%0d cyc=%0d", oDATA_s, cyc);
            end else begin
                e = q_s.pop_front();
                if (oDATA_s !== 12'(e.val) || oFSTART_s !== e.fs || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL sat_px got data=%0d fs=%0b cyc=%0d want data=%0d fs=%0b cyc=%0d",
                             oDATA_s, oFSTART_s, cyc, e.val, e.fs, e.cyc);
                end
            end
        end
    end

    initial begin
        iRST = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check_zero_out("reset");
        iRST = 1'b1;
        repeat (2) idle();

        send_frame(0, 2'b01, 2'b01, 0, 0, 0);
        send_frame(0, 2'b10, 2'b10, 0, 0, 0);
        send_frame(1, 2'b10, 2'b10, 0, 0, 0);
        send_frame(2, 2'b00, 2'b00, 0, 0, 0);
        send_frame(0, 2'b01, 2'b01, 60, 60, 0);
        send_frame(0, 2'b01, 2'b01, 50, 50, 0);
        send_frame(0, 2'b01, 2'b10, 0, 0, 0);
        send_frame(0, 2'b10, 2'b10, 0, 0, 0);
        send_frame(1, 2'b11, 2'b11, 0, 0, 0);
        send_frame(3, 2'b00, 2'b00, 0, 0, 0);
        send_frame(3, 2'b00, 2'b00, 0, 0, 30);
        send_frame(1, 2'b01, 2'b01, 0, 0, 30);

        // Mid-frame reset: counters restart at (0,0) without a frame pulse
        for (int k = 0; k < 20; k++)
            issue(k == 0, 2'b01, 0, pix(0, k/8, k%8), k/8, k%8);
        @(posedge iCLK); #1;
        iRST    = 1'b0;
        iDVAL   = 1'b0;
        iFSTART = 1'b0;
        @(posedge iCLK); #1;
        q_m.delete();
        q_s.delete();
        check_zero_out("midreset");
        iRST   = 1'b1;
        mode_m = 2'b00;
        thr_m  = 0;
        for (int k = 0; k < 24; k++)
            issue(1'b0, 2'b01, 0, pix(0, k/8, k%8), k/8, k%8);
        repeat (4) idle();
        send_frame(0, 2'b01, 2'b01, 0, 0, 0);

        for (int i = 0; i < 20 && (q_m.size() != 0 || q_s.size() != 0); i++)
            @(posedge iCLK);
        @(negedge iCLK);
        chk("drain_main", q_m.size(), 0);
        chk("drain_sat", q_s.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv3x3_edge_engine.md
Name: conv3x3_edge_engine

Overview:
- Parametrised single-clock 3x3 window engine with selectable gradient or bypass output.
- Generalises the grayscale row buffer, Sobel and absolute-value stages into one block with:
  - configurable pixel width and row length,
  - frame-synchronised mode and threshold latching,
  - explicit border zeroing,
  - output saturation.
- Sits between grayscale/smoothing and the SDRAM write path. Accepts one pixel per iDVAL and emits one result per input pixel.

Parameters:
- DW, 12, pixel data width (input and output).
- ROW_WIDTH, 640, pixels per row; sets the depth of each of the 2 line buffers.
- SHIFT, 3, right shift applied to the gradient magnitude before saturation.
- CW, 11, column counter width; must satisfy 2^CW >= ROW_WIDTH.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  reset; synchronous, active-low.
- iDATA  in  DW  grayscale pixel, raster order.
- iDVAL  in  1  iDATA valid; no backpressure.
- iFSTART  in  1  one-cycle frame-start pulse; may coincide with iDVAL.
- iMode  in  2  00 = |Gx|+|Gy|, 01 = |Gx|, 10 = |Gy|, 11 = bypass (window centre pixel).
- iThresh  in  DW  noise threshold; applied in modes 00/01/10 only.
- oDATA  out  DW  result pixel.
- oDVAL  out  1  oDATA valid.
- oFSTART  out  1  iFSTART delayed to align with oDATA.

Behaviour:
- Reset:
  - All internal and output registers cleared on the iCLK edge where iRST = 0: oDATA = 0, oDVAL = 0, oFSTART = 0, col = 0, row = 0, mode_q = 00, thresh_q = 0.
  - Line-buffer RAM is not cleared. Border forcing masks stale contents.
- Counters:
  - col increments on each iDVAL. At ROW_WIDTH-1 it wraps to 0 and row increments.
  - row saturates at 2; only row >= 2 matters.
  - iFSTART sets col = 0 and row = 0. If iDVAL is high in the same cycle, that pixel is position (0,0) and col becomes 1.
  - Latching on iFSTART: mode_q <= iMode, thresh_q <= iThresh. Changes to iMode/iThresh between pulses have no effect.
- Line buffers:
  - Two RAMs, depth ROW_WIDTH, addressed by col.
  - On iDVAL: tap1 = read of buffer A, tap2 = read of buffer B. Then A <= iDATA and B <= old A.
- Window:
  - 3x3 register window shifts left by one column on iDVAL only. The new column is {iDATA, tap1, tap2}.
  - The centre pixel is at input position (row-1, col-1).
- Border: the result is forced to 0 in all modes when the input row < 2 or the input col < 2 at the pixel that completes the window.
- Pipeline:
  - Fixed latency of 3 cycles: oDVAL(t+3) = iDVAL(t) and oFSTART(t+3) = iFSTART(t).
  - Stage 1: window shift. Stage 2: Gx/Gy. Stage 3: magnitude/scale/threshold.
  - The pipeline advances every cycle. Data registers hold their value when the corresponding valid is 0.
- Arithmetic:
  - Gx = (right column, weights 1,2,1) - (left column, weights 1,2,1).
  - Gy = (bottom row, weights 1,2,1) - (top row, weights 1,2,1).
  - Gx and Gy are signed, DW+3 bits.
  - Magnitude: |Gx|+|Gy| in mode 00, |Gx| in mode 01, |Gy| in mode 10. Magnitude is unsigned, DW+4 bits.
  - Scaled value = magnitude >> SHIFT, saturated to 2^DW - 1. If scaled < thresh_q, the result is 0.
- Mode 11: oDATA = centre pixel unmodified, subject to border forcing only.
- Mid-frame reset: outputs drop to 0 on the next edge. Counters start at (0,0) with the first post-reset iDVAL, even without iFSTART.
- Gaps: iDVAL gaps of any length, including across row ends, do not alter the results.

Test Plan:
- ROW_WIDTH=8, SHIFT=3, mode 01, thresh 0; every row has cols 0-3 = 0 and cols 4-7 = 100 -> rows >= 2: oDATA = 50 at input cols 4,5, all else 0; rows 0-1 all 0; oDVAL exactly 3 cycles after each iDVAL.
- Same image, mode 10 -> all oDATA = 0. Transposed image (rows 0-3 = 0, rows 4-7 = 100), mode 10 -> 50 at input rows 4,5, cols >= 2.
- DW=12, SHIFT=0, mode 00, step 0 -> 4095 -> magnitude 16380 saturates -> oDATA = 4095.
- First image, thresh 60 -> all 0; thresh 50 -> 50 retained.
- iMode changed from 01 to 10 mid-frame -> output still follows |Gx| until the next iFSTART, then follows |Gy|.
- Random iDVAL gaps (30% idle) vs. continuous stream of identical data -> identical oDATA sequence. iRST=0 for 1 cycle mid-frame -> oDVAL = 0 and oDATA = 0 next edge; the next two rows output 0.
